param_cache: RTL and testbench

PARAM_CACHE -- requirements
Module: param_cache

---
 rtl/param_cache.sv | 224 ++++++++++++++++++++++
 tb/tb_param_cache.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cache.sv
// rtl/param_cache.sv - blocking set-associative write-back cache with LRU replacement
//
// Purpose: WAYS-way, 2^SET_BITS-set cache with 2^OFF_BITS-byte lines. It accepts one
// CPU request at a time. Read hits answer in the lookup cycle. Misses write back a
// dirty victim, then refill the line one word per ret_valid beat.
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   valid/op/index/tag/offset       CPU request (op=1 write), accepted when addr_ok
//   wstrb/wdata                     write byte enables and data
//   addr_ok, data_ok, rdata         request accept, completion pulse, read data
//   rd_req/rd_type/rd_addr/rd_rdy   line refill request
//   ret_valid/ret_last/ret_data     refill data beats
//   wr_req/wr_type/wr_addr/
//   wr_wstrb/wr_data/wr_rdy         dirty line write-back
module param_cache #(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 8,
  parameter int OFF_BITS = 4,
  localparam int LW      = 2 ** (OFF_BITS - 2),
  localparam int TAG_W   = 32 - SET_BITS - OFF_BITS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                valid,
  input  logic                op,
  input  logic [SET_BITS-1:0] index,
  input  logic [TAG_W-1:0]    tag,
  input  logic [OFF_BITS-1:0] offset,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [31:0]         rdata,
  output logic                rd_req,
  output logic [2:0]          rd_type,
  output logic [31:0]         rd_addr,
  input  logic                rd_rdy,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [31:0]         ret_data,
  output logic                wr_req,
  output logic [2:0]          wr_type,
  output logic [31:0]         wr_addr,
  output logic [3:0]          wr_wstrb,
  output logic [32*LW-1:0]    wr_data,
  input  logic                wr_rdy
);
  localparam int SETS  = 2 ** SET_BITS;
  localparam int WAY_W = $clog2(WAYS);
  localparam int CNT_W = OFF_BITS - 2;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_REPLACE, S_REFILL} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0] tag_a  [SETS][WAYS];
  logic [WAYS-1:0]  valid_a[SETS];
  logic [WAYS-1:0]  dirty_a[SETS];
  logic [WAY_W-1:0] age_a  [SETS][WAYS];
  logic [31:0]      data_a [SETS][WAYS][LW];

  logic                op_r;
  logic [SET_BITS-1:0] index_r;
  logic [TAG_W-1:0]    tag_r;
  logic [CNT_W-1:0]    woff_r;
  logic [3:0]          wstrb_r;
  logic [31:0]         wdata_r;
  logic [WAY_W-1:0]    victim_r;
  logic [CNT_W-1:0]    cnt;

  logic             hit;
  logic [WAY_W-1:0] hit_way, vic_sel, acc_way;
  logic             vic_found, lru_upd;

  // Only the word part of the offset matters; byte lanes are selected by wstrb.
  logic unused_off;
  assign unused_off = ^offset[1:0];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  // Tag compare and victim choice (lowest invalid way, else the oldest way).
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    vic_sel   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_a[index_r][w] && tag_a[index_r][w] == tag_r) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!vic_found && !valid_a[index_r][w]) begin
        vic_found = 1'b1;
        vic_sel   = WAY_W'(w);
      end
    end
    if (!vic_found)
      for (int w = 0; w < WAYS; w++)
        if (age_a[index_r][w] == WAY_W'(WAYS - 1)) vic_sel = WAY_W'(w);
  end

  assign acc_way  = (state == S_LOOKUP) ? hit_way : victim_r;
  assign lru_upd  = (state == S_LOOKUP && hit) || (state == S_REFILL && ret_valid && ret_last);
  assign rd_type  = 3'b100;
  assign rd_addr  = {tag_r, index_r, {OFF_BITS{1'b0}}};
  assign wr_type  = 3'b100;
  assign wr_wstrb = 4'hF;
  assign wr_addr  = {tag_a[index_r][victim_r], index_r, {OFF_BITS{1'b0}}};

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < LW; i++) wr_data[32*i +: 32] = data_a[index_r][victim_r][i];
  end

  always_comb begin
    state_nxt = state;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    rdata     = '0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    // Outputs are forced to their idle values while reset is asserted, whatever the state.
    if (!resetn) begin
      addr_ok = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          addr_ok = 1'b1;
          if (valid) state_nxt = S_LOOKUP;
        end
        S_LOOKUP: begin
          if (hit) begin
            data_ok = 1'b1;
            if (!op_r) rdata = data_a[index_r][hit_way][woff_r];
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_MISS;
          end
        end
        S_MISS: begin
          if (valid_a[index_r][victim_r] && dirty_a[index_r][victim_r]) begin
            wr_req = 1'b1;
            if (wr_rdy) state_nxt = S_REPLACE;
          end else begin
            state_nxt = S_REPLACE;
          end
        end
        S_REPLACE: begin
          rd_req = 1'b1;
          if (rd_rdy) state_nxt = S_REFILL;
        end
        S_REFILL: begin
          if (ret_valid) begin
            if (cnt == woff_r) begin
              data_ok = 1'b1;
              if (!op_r) rdata = ret_data;
            end
            if (ret_last) state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Control state, request latch, valid/dirty/LRU bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_a[s] <= '0;
        dirty_a[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_a[s][w] <= WAY_W'(w);
      end
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && valid) begin
        op_r    <= op;
        index_r <= index;
        tag_r   <= tag;
        woff_r  <= offset[OFF_BITS-1:2];
        wstrb_r <= wstrb;
        wdata_r <= wdata;
      end
      if (state == S_LOOKUP) begin
        if (hit && op_r) dirty_a[index_r][hit_way] <= 1'b1;
        if (!hit) victim_r <= vic_sel;
      end
      if (state == S_REFILL && ret_valid) begin
        cnt <= cnt + 1'b1;
        if (ret_last) begin
          cnt                         <= '0;
          valid_a[index_r][victim_r] <= 1'b1;
          dirty_a[index_r][victim_r] <= op_r;
        end
      end
      // Accessed way becomes youngest; only ways younger than it age by one.
      if (lru_upd)
        for (int w = 0; w < WAYS; w++)
          if (WAY_W'(w) == acc_way)
            age_a[index_r][w] <= '0;
          else if (age_a[index_r][w] < age_a[index_r][acc_way])
            age_a[index_r][w] <= age_a[index_r][w] + 1'b1;
    end
  end

  // Line data and tags need no reset: the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state == S_LOOKUP && hit && op_r)
        data_a[index_r][hit_way][woff_r] <= merge(data_a[index_r][hit_way][woff_r], wdata_r, wstrb_r);
      if (state == S_REFILL && ret_valid) begin
        data_a[index_r][victim_r][cnt] <= (op_r && cnt == woff_r) ?
                                          merge(ret_data, wdata_r, wstrb_r) : ret_data;
        if (ret_last) tag_a[index_r][victim_r] <= tag_r;
      end
    end
  end
endmodule

// File: tb/tb_param_cache.sv
// tb/tb_param_cache.sv - randomized self-checking bench for param_cache against a cache and memory model
module tb_param_cache;
  localparam int P_LOOK = 0, P_WB = 1, P_MC = 2, P_RQ = 3, P_RF = 4, P_END = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic valid = 1'b0, op = 1'b0;
  logic [7:0] index = '0;
  logic [19:0] tag = '0;
  logic [3:0] offset = '0, wstrb = '0;
  logic [31:0] wdata = '0;
  logic addr_ok, data_ok;
  logic [31:0] rdata;
  logic rd_req;
  logic [2:0] rd_type;
  logic [31:0] rd_addr;
  logic rd_rdy = 1'b0, ret_valid = 1'b0, ret_last = 1'b0;
  logic [31:0] ret_data = '0;
  logic wr_req;
  logic [2:0] wr_type;
  logic [31:0] wr_addr;
  logic [3:0] wr_wstrb;
  logic [127:0] wr_data;
  logic wr_rdy = 1'b0;

  param_cache #(.WAYS(2), .SET_BITS(8), .OFF_BITS(4)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .index(index), .tag(tag),
    .offset(offset), .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data), .wr_req(wr_req),
    .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference state: backing memory, CPU-visible memory image, and a cache directory.
  logic [31:0] mem  [bit [31:0]];
  logic [31:0] gold [bit [31:0]];
  bit          m_valid[256][2];
  bit          m_dirty[256][2];
  logic [19:0] m_tag  [256][2];
  logic [31:0] m_data [256][2][4];
  int          mru    [256];

  // Per-request observations, used by the directed checks.
  bit           saw_rd, saw_wr;
  int           n_ok, ok_cyc, rd_first, wr_cycles;
  logic [31:0]  last_rdata, last_rd_addr, last_wr_addr;
  logic [127:0] last_wr_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return mem_rd(a);
  endfunction

  // After reset the cache forgets dirty data, so the CPU sees plain memory again.
  task automatic model_reset();
    for (int s = 0; s < 256; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      mru[s] = 0;
    end
    gold.delete();
  endtask

  task automatic do_req(input logic op_i, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int stall_i, input int rst_beat);
    int s, wo, hw, vw, ph, beat, stall;
    logic [19:0] t;
    logic [31:0] base, waddr, exp_rdata, exp_wb_addr;
    logic [127:0] exp_wb_data;
    bit hit, vdirty, done, aborted, exp_ok;
    s = int'(addr[11:4]);
    t = addr[31:12];
    wo = int'(addr[3:2]);
    base = {addr[31:4], 4'h0};
    waddr = {addr[31:2], 2'b00};
    hit = 1'b0;
    hw = 0;
    for (int w = 0; w < 2; w++)
      if (!hit && m_valid[s][w] && m_tag[s][w] == t) begin
        hit = 1'b1;
        hw = w;
      end
    if (!m_valid[s][0]) vw = 0;
    else if (!m_valid[s][1]) vw = 1;
    else vw = 1 - mru[s];
    vdirty = !hit && m_valid[s][vw] && m_dirty[s][vw];
    exp_wb_addr = {m_tag[s][vw], addr[11:4], 4'h0};
    for (int i = 0; i < 4; i++) exp_wb_data[32*i +: 32] = m_data[s][vw][i];
    exp_rdata = gold_rd(waddr);
    saw_rd = 0; saw_wr = 0; n_ok = 0; ok_cyc = -1; rd_first = -1; wr_cycles = 0;

    @(negedge clk);
    valid = 1'b1; op = op_i; index = addr[11:4]; tag = addr[31:12]; offset = addr[3:0];
    wstrb = be; wdata = wd;
    rd_rdy = 1'b0; wr_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
    #1 chk("accept_addr_ok", addr_ok, 1'b1);
    ph = P_LOOK; beat = 0; stall = stall_i; done = 0; aborted = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      valid = (ph != P_END) ? 1'($urandom_range(0, 1)) : 1'b0;
      op = 1'($urandom); index = 8'($urandom); tag = 20'($urandom); offset = 4'($urandom);
      wstrb = 4'($urandom); wdata = $urandom;
      rd_rdy = 1'b0; wr_rdy = 1'b0; ret_data = $urandom;
      ret_last = 1'($urandom_range(0, 1));
      ret_valid = (ph != P_RF) && ($urandom_range(0, 3) == 0);
      exp_ok = 1'b0;
      case (ph)
        P_LOOK: exp_ok = hit;
        P_WB:   wr_rdy = (stall == 0);
        P_RQ:   rd_rdy = 1'($urandom_range(0, 1));
        P_RF: begin
          ret_valid = 1'b0;
          if (beat == rst_beat) begin
            resetn = 1'b0;
            ret_valid = 1'b1;
            ret_last = 1'b0;
            ret_data = mem_rd(base + 32'(4 * beat));
          end else if ($urandom_range(0, 2) != 0) begin
            ret_valid = 1'b1;
            ret_last = (beat == 3);
            ret_data = mem_rd(base + 32'(4 * beat));
            exp_ok = (beat == wo);
          end
        end
        default: ;
      endcase
      #1;
      chk("data_ok", data_ok, exp_ok && resetn);
      if (!(data_ok && op_i)) chk("rdata", rdata, (exp_ok && !op_i && resetn) ? exp_rdata : 32'h0);
      chk("addr_ok", addr_ok, (ph == P_END) || !resetn);
      chk("wr_req", wr_req, (ph == P_WB) && resetn);
      chk("rd_req", rd_req, (ph == P_RQ) && resetn);
      if (wr_req) begin
        chk("wr_addr", wr_addr, exp_wb_addr);
        chk("wr_data", wr_data, exp_wb_data);
        chk("wr_type", wr_type, 3'b100);
        chk("wr_wstrb", wr_wstrb, 4'hF);
        wr_cycles++; saw_wr = 1; last_wr_addr = wr_addr; last_wr_data = wr_data;
        if (wr_rdy) for (int i = 0; i < 4; i++) mem[wr_addr + 32'(4 * i)] = wr_data[32*i +: 32];
      end
      if (rd_req) begin
        chk("rd_addr", rd_addr, base);
        chk("rd_type", rd_type, 3'b100);
        if (!saw_rd) rd_first = cyc;
        saw_rd = 1; last_rd_addr = rd_addr;
      end
      if (data_ok) begin
        n_ok++; last_rdata = rdata; ok_cyc = cyc;
      end
      if (!resetn) begin
        aborted = 1; done = 1;
      end else begin
        case (ph)
          P_LOOK: ph = hit ? P_END : (vdirty ? P_WB : P_MC);
          P_WB:   if (stall == 0) ph = P_RQ; else stall--;
          P_MC:   ph = P_RQ;
          P_RQ:   if (rd_rdy) ph = P_RF;
          P_RF:   if (ret_valid) begin if (beat == 3) ph = P_END; beat++; end
          default: done = 1;
        endcase
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: request to %h never completed", addr);
    end else if (aborted) begin
      chk("aborted_no_data_ok", 32'(n_ok), 32'd0);
    end else begin
      chk("one_data_ok", 32'(n_ok), 32'd1);
      if (hit) vw = hw;
      else begin
        for (int i = 0; i < 4; i++) m_data[s][vw][i] = mem_rd(base + 32'(4 * i));
        m_valid[s][vw] = 1'b1; m_tag[s][vw] = t; m_dirty[s][vw] = 1'b0;
      end
      if (op_i) begin
        m_data[s][vw][wo] = merge(m_data[s][vw][wo], wd, be);
        m_dirty[s][vw] = 1'b1;
        gold[waddr] = merge(gold_rd(waddr), wd, be);
      end
      mru[s] = vw;
    end
  endtask

  task automatic chk_idle_outputs(input string tagname);
    chk({tagname, "_addr_ok"}, addr_ok, 1'b1);
    chk({tagname, "_data_ok"}, data_ok, 1'b0);
    chk({tagname, "_rd_req"}, rd_req, 1'b0);
    chk({tagname, "_wr_req"}, wr_req, 1'b0);
    chk({tagname, "_rdata"}, rdata, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    model_reset();
    mem[32'h1230] = 32'h11; mem[32'h1234] = 32'h22;
    mem[32'h1238] = 32'h33; mem[32'h123C] = 32'h44;
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 chk_idle_outputs("in_reset");
    end
    @(negedge clk);
    resetn = 1'b1;
    #1 chk_idle_outputs("after_reset");

    do_req(1'b0, 32'h0000_1234, 4'h0, 32'h0, 0, -1);
    chk("cold_rd_req", saw_rd, 1'b1);
    chk("cold_rd_addr", last_rd_addr, 32'h0000_1230);
    chk("cold_rdata", last_rdata, 32'h22);
    do_req(1'b0, 32'h0000_1234, 4'h0, 32'h0, 0, -1);
    chk("reread_no_rd", saw_rd, 1'b0);
    chk("reread_in_lookup", 32'(ok_cyc), 32'd0);
    chk("reread_rdata", last_rdata, 32'h22);
    do_req(1'b1, 32'h0000_1234, 4'b0011, 32'hAAAA_BBBB, 0, -1);
    chk("wr_hit_in_lookup", 32'(ok_cyc), 32'd0);
    chk("wr_hit_no_rd", saw_rd, 1'b0);
    do_req(1'b0, 32'h0000_1234, 4'h0, 32'h0, 0, -1);
    chk("merged_rdata", last_rdata, 32'h0000_BBBB);
    do_req(1'b0, 32'h0000_2234, 4'h0, 32'h0, 0, -1);
    chk("fill_way1_no_wb", saw_wr, 1'b0);
    do_req(1'b0, 32'h0000_3234, 4'h0, 32'h0, 0, -1);
    chk("evict_dirty_wb", saw_wr, 1'b1);
    chk("evict_wr_addr", last_wr_addr, 32'h0000_1230);
    chk("evict_wr_data", last_wr_data, 128'h00000044_00000033_0000BBBB_00000011);
    chk("evict_rd_addr", last_rd_addr, 32'h0000_3230);
    do_req(1'b0, 32'h0000_4234, 4'h0, 32'h0, 0, -1);
    chk("clean_evict_no_wb", saw_wr, 1'b0);
    chk("clean_evict_rd_cycle", 32'(rd_first), 32'd2);
    do_req(1'b1, 32'h0000_4238, 4'hF, 32'hCAFE_F00D, 0, -1);
    do_req(1'b0, 32'h0000_5234, 4'h0, 32'h0, 0, -1);
    do_req(1'b0, 32'h0000_6234, 4'h0, 32'h0, 10, -1);
    chk("stall_wr_cycles", 32'(wr_cycles), 32'd11);
    chk("stall_wr_addr", last_wr_addr, 32'h0000_4230);

    do_req(1'b0, 32'h0000_1234, 4'h0, 32'h0, 0, 1);
    chk("reset_mid_refill_no_ok", 32'(n_ok), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    #1 chk_idle_outputs("post_abort");
    do_req(1'b0, 32'h0000_1234, 4'h0, 32'h0, 0, -1);
    chk("post_reset_miss", saw_rd, 1'b1);

    for (int n = 0; n < 300; n++) begin
      a = {16'h0, 4'($urandom_range(1, 5)), 8'h40 + 8'($urandom_range(0, 3)), 4'($urandom)};
      do_req(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, $urandom_range(0, 3), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
